// File: rtl/serializer_pipe.sv
// Ready/valid word-to-bit serializer with variable length, MSB/LSB-first order and a one-word pending buffer.
// Optional trailing even-parity bit per word when SERIALIZER_PARITY_EN is defined.
module serializer_pipe #(
    parameter int DATA_W  = 16,
    parameter int MOD_W   = $clog2(DATA_W),
    parameter int MIN_MOD = 3
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              data_val_i,
    output logic              data_rdy_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              lsb_first_i,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              ser_last_o,
    output logic              drop_o,
    output logic              busy_o
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [MOD_W:0] FULL_L = (MOD_W+1)'(DATA_W);
    localparam logic [MOD_W:0] MIN_L  = (MOD_W+1)'(MIN_MOD);
    localparam logic [MOD_W:0] ONE    = (MOD_W+1)'(1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [MOD_W:0]    cnt_q, cnt_d;
    logic              lsb_q, lsb_d;
    logic              pend_vld_q, pend_vld_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic [MOD_W:0]    pend_len_q, pend_len_d;
    logic              pend_lsb_q, pend_lsb_d;
    logic              drop_q, drop_d;
    logic              run_q;
    logic              busy_q;
`ifdef SERIALIZER_PARITY_EN
    logic              par_q, par_d;
    logic              par_ph_q, par_ph_d;
`endif

    logic              accept;
    logic [MOD_W:0]    in_len;
    logic              in_ok;
    logic              cur_bit;
    logic              word_end;
    logic              load_in;
    logic              load_pend;

    assign data_rdy_o = run_q & ~pend_vld_q;
    assign accept     = data_val_i & data_rdy_o;
    assign in_len     = (data_mod_i == '0) ? FULL_L : {1'b0, data_mod_i};
    assign in_ok      = (in_len >= MIN_L);
    assign cur_bit    = lsb_q ? shift_q[0] : shift_q[DATA_W-1];
    assign drop_o     = drop_q;
    // busy lingers one cycle past the final serial bit
    assign busy_o     = busy_q | (state_q == SHIFT) | pend_vld_q;

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        cnt_d          = cnt_q;
        lsb_d          = lsb_q;
        pend_vld_d     = pend_vld_q;
        pend_data_d    = pend_data_q;
        pend_len_d     = pend_len_q;
        pend_lsb_d     = pend_lsb_q;
        drop_d         = accept & ~in_ok;
        ser_data_o     = 1'b0;
        ser_data_val_o = 1'b0;
        ser_last_o     = 1'b0;
        word_end       = 1'b0;
        load_in        = 1'b0;
        load_pend      = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        par_d          = par_q;
        par_ph_d       = par_ph_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept && in_ok) load_in = 1'b1;
            end
            SHIFT: begin
                ser_data_val_o = 1'b1;
`ifdef SERIALIZER_PARITY_EN
                if (par_ph_q) begin
                    ser_data_o = par_q;
                    ser_last_o = 1'b1;
                    word_end   = 1'b1;
                end else begin
                    ser_data_o = cur_bit;
                    par_d      = par_q ^ cur_bit;
                    shift_d    = lsb_q ? (shift_q >> 1) : (shift_q << 1);
                    cnt_d      = cnt_q - ONE;
                    if (cnt_q == ONE) par_ph_d = 1'b1;
                end
`else
                ser_data_o = cur_bit;
                shift_d    = lsb_q ? (shift_q >> 1) : (shift_q << 1);
                cnt_d      = cnt_q - ONE;
                if (cnt_q == ONE) begin
                    ser_last_o = 1'b1;
                    word_end   = 1'b1;
                end
`endif
                // On the final bit, chain straight into the next word so the line has no gap
                if (word_end) begin
                    if (pend_vld_q)              load_pend = 1'b1;
                    else if (accept && in_ok)    load_in   = 1'b1;
                    else                         state_d   = IDLE;
                end else if (accept && in_ok) begin
                    pend_vld_d  = 1'b1;
                    pend_data_d = data_i;
                    pend_len_d  = in_len;
                    pend_lsb_d  = lsb_first_i;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_in) begin
            state_d = SHIFT;
            shift_d = data_i;
            cnt_d   = in_len;
            lsb_d   = lsb_first_i;
`ifdef SERIALIZER_PARITY_EN
            par_d    = 1'b0;
            par_ph_d = 1'b0;
`endif
        end
        if (load_pend) begin
            state_d    = SHIFT;
            shift_d    = pend_data_q;
            cnt_d      = pend_len_q;
            lsb_d      = pend_lsb_q;
            pend_vld_d = 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par_d    = 1'b0;
            par_ph_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            lsb_q       <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_data_q <= '0;
            pend_len_q  <= '0;
            pend_lsb_q  <= 1'b0;
            drop_q      <= 1'b0;
            run_q       <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par_q       <= 1'b0;
            par_ph_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            lsb_q       <= lsb_d;
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
            pend_len_q  <= pend_len_d;
            pend_lsb_q  <= pend_lsb_d;
            drop_q      <= drop_d;
            run_q       <= 1'b1;
            busy_q      <= (state_q == SHIFT);
`ifdef SERIALIZER_PARITY_EN
            par_q       <= par_d;
            par_ph_q    <= par_ph_d;
`endif
        end
    end

endmodule

// File: tb/tb_serializer_pipe.sv
// Directed bench for serializer_pipe; expected bit streams are written out by hand.
module tb_serializer_pipe;

    localparam int DATA_W = 16;
    localparam int MOD_W  = 4;
`ifdef SERIALIZER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic              clk = 1'b0;
    logic              srst = 1'b0;
    logic              data_val = 1'b0;
    logic              data_rdy;
    logic [DATA_W-1:0] data = '0;
    logic [MOD_W-1:0]  data_mod = '0;
    logic              lsb_first = 1'b0;
    logic              ser_data, ser_val, ser_last, drop, busy;

    int checks = 0;
    int errors = 0;

    serializer_pipe #(.DATA_W(DATA_W), .MIN_MOD(3)) dut (
        .clk_i(clk), .srst_i(srst), .data_val_i(data_val), .data_rdy_o(data_rdy),
        .data_i(data), .data_mod_i(data_mod), .lsb_first_i(lsb_first),
        .ser_data_o(ser_data), .ser_data_val_o(ser_val), .ser_last_o(ser_last),
        .drop_o(drop), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_bit(input string tag, input logic b, input logic last);
        chk({tag, "_val"}, ser_val, 1'b1);
        chk({tag, "_bit"}, ser_data, b);
        chk({tag, "_last"}, ser_last, last);
        tick();
    endtask

    // bits[n-1] is the first bit on the line
    task automatic expect_word(input string tag, input logic [15:0] bits, input int n, input logic par);
        for (int i = n - 1; i >= 0; i--)
            expect_bit(tag, bits[i], (P == 0) && (i == 0));
        if (P == 1) expect_bit({tag, "_par"}, par, 1'b1);
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] m, input logic lsb);
        int n = 0;
        while (!data_rdy && n < 50) begin
            tick();
            n++;
        end
        chk("rdy_wait", data_rdy, 1'b1);
        data_val  = 1'b1;
        data      = d;
        data_mod  = m;
        lsb_first = lsb;
        tick();
        data_val  = 1'b0;
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, "_val"}, ser_val, 1'b0);
        chk({tag, "_bit"}, ser_data, 1'b0);
        chk({tag, "_last"}, ser_last, 1'b0);
    endtask

    initial begin
        #2 srst = 1'b1;
        #1;
        expect_idle("rst");
        chk("rst_rdy", data_rdy, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_drop", drop, 1'b0);
        tick();
        tick();
        srst = 1'b0;
        chk("rel_rdy0", data_rdy, 1'b0);
        tick();
        chk("rel_rdy1", data_rdy, 1'b1);
        chk("rel_busy", busy, 1'b0);

        // Full 16-bit word, MSB-first
        send(16'hA5F0, 4'd0, 1'b0);
        chk("a5f0_busy", busy, 1'b1);
        expect_word("a5f0", 16'hA5F0, 16, 1'b0);
        expect_idle("a5f0_end");
        tick();

        // Minimum length word, busy tail
        send(16'hE000, 4'd3, 1'b0);
        expect_word("e000", 16'h0007, 3, 1'b1);
        expect_idle("e000_end");
        chk("e000_busy_tail", busy, 1'b1);
        tick();
        chk("e000_busy_low", busy, 1'b0);

`ifdef SERIALIZER_PARITY_EN
        send(16'hC000, 4'd3, 1'b0);
        expect_word("c000", 16'h0006, 3, 1'b0);
        expect_idle("c000_end");
        tick();
        tick();
`endif

        // LSB-first
        send(16'h000B, 4'd4, 1'b1);
        expect_word("b_lsb", 16'h000D, 4, 1'b1);
        expect_idle("b_lsb_end");
        tick();
        tick();

        // Back-to-back words: second one sits in pending
        send(16'hF000, 4'd4, 1'b0);
        data_val = 1'b1;
        data     = 16'h0000;
        data_mod = 4'd4;
        expect_bit("b2b0", 1'b1, 1'b0);
        data_val = 1'b0;
        chk("b2b_rdy_low", data_rdy, 1'b0);
        chk("b2b_busy", busy, 1'b1);
        expect_bit("b2b1", 1'b1, 1'b0);
        expect_bit("b2b2", 1'b1, 1'b0);
        expect_bit("b2b3", 1'b1, P == 0);
        if (P == 1) expect_bit("b2b_par1", 1'b0, 1'b1);
        chk("b2b_rdy_back", data_rdy, 1'b1);
        expect_word("b2b_w2", 16'h0000, 4, 1'b0);
        expect_idle("b2b_end");
        tick();
        tick();

        // Too-short words are dropped
        send(16'hFFFF, 4'd2, 1'b0);
        chk("drop2_pulse", drop, 1'b1);
        chk("drop2_busy", busy, 1'b0);
        expect_idle("drop2");
        tick();
        chk("drop2_clear", drop, 1'b0);
        chk("drop2_val", ser_val, 1'b0);
        send(16'hFFFF, 4'd1, 1'b1);
        chk("drop1_pulse", drop, 1'b1);
        chk("drop1_busy", busy, 1'b0);
        expect_idle("drop1");
        tick();
        chk("drop1_clear", drop, 1'b0);

        // Async reset mid-word with a word pending
        send(16'hFFFF, 4'd0, 1'b0);
        data_val = 1'b1;
        data     = 16'h00FF;
        data_mod = 4'd0;
        expect_bit("mid0", 1'b1, 1'b0);
        data_val = 1'b0;
        chk("mid_pend_rdy", data_rdy, 1'b0);
        for (int i = 1; i < 5; i++) expect_bit("mid", 1'b1, 1'b0);
        srst = 1'b1;
        #1;
        expect_idle("async_rst");
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_rdy", data_rdy, 1'b0);
        tick();
        srst = 1'b0;
        tick();
        chk("post_rst_rdy", data_rdy, 1'b1);
        chk("post_rst_busy", busy, 1'b0);
        send(16'h000B, 4'd4, 1'b1);
        expect_word("post_rst", 16'h000D, 4, 1'b1);
        expect_idle("post_rst_end");
        tick();
        tick();
        expect_idle("pend_lost");
        chk("pend_lost_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
